// File: rtl/if_id_stage_pkg.sv
// Shared constants for the IF/ID boundary: bus widths, RV32I opcodes used by
// the hazard decode, the injected NOP and the hazard FSM state encoding.
package if_id_stage_pkg;

   localparam int WIDTH_INST = 32;
   localparam int WIDTH_PC   = 32;

   localparam logic [WIDTH_INST-1:0] NOP_INST = 32'h0000_0013;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MEM_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Combinational load-use detector: decodes which source registers the ID
// instruction reads and compares them against the load destination in EX.
module hazard_detect
   import if_id_stage_pkg::*;
(
   input  logic [WIDTH_INST-1:0] inst,
   input  logic                  valid,
   input  logic                  ex_mem_read,
   input  logic [4:0]            ex_rd,
   output logic                  load_use
);

   logic [6:0] opcode;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       rs1_used;
   logic       rs2_used;
   logic       rs1_hit;
   logic       rs2_hit;

   assign opcode = inst[6:0];
   assign rs1    = inst[19:15];
   assign rs2    = inst[24:20];

   // U-type and JAL carry immediate bits in the rs1 field, so they never match.
   assign rs1_used = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
   assign rs2_used = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);

   assign rs1_hit = rs1_used && (rs1 == ex_rd);
   assign rs2_hit = rs2_used && (rs2 == ex_rd);

   assign load_use = valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use / memory-stall hazard control and a
// saturating stall-cycle counter; one cycle IF->ID latency when not stalled.
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter logic [WIDTH_INST-1:0] NOP_INST = if_id_stage_pkg::NOP_INST,
   parameter int                    CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH_INST-1:0] inst_IF,
   input  logic [WIDTH_PC-1:0]   pc_IF,
   input  logic                  flush,
   input  logic                  mem_busy,
   input  logic                  ex_memRead,
   input  logic [4:0]            ex_rd,
   output logic [WIDTH_INST-1:0] inst_ID,
   output logic [WIDTH_PC-1:0]   pc_ID,
   output logic                  valid_ID,
   output logic                  stop_IF,
   output logic                  bubble_EX,
   output logic [CNT_W-1:0]      stall_cnt
);

   state_t state;
   state_t state_nxt;
   logic   load_use;
   logic   lu_run;

   hazard_detect u_hazard_detect (
      .inst        (inst_ID),
      .valid       (valid_ID),
      .ex_mem_read (ex_memRead),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   // LU_STALL only lasts one cycle, so a hazard seen there is not re-stalled.
   assign lu_run    = (state == ST_RUN) && load_use;
   assign stop_IF   = rst_n && !flush && (mem_busy || lu_run);
   assign bubble_EX = rst_n && !flush && !mem_busy && lu_run;

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_RUN;
      end else if (mem_busy) begin
         state_nxt = ST_MEM_HOLD;
      end else begin
         case (state)
            ST_RUN:      state_nxt = load_use ? ST_LU_STALL : ST_RUN;
            ST_LU_STALL: state_nxt = ST_RUN;
            ST_MEM_HOLD: state_nxt = ST_RUN;
            default:     state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Flush beats a simultaneous memory stall: fetch is already redirecting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_ID  <= NOP_INST;
         pc_ID    <= '0;
         valid_ID <= 1'b0;
      end else if (flush) begin
         inst_ID  <= NOP_INST;
         pc_ID    <= pc_IF;
         valid_ID <= 1'b0;
      end else if (!stop_IF) begin
         inst_ID  <= inst_IF;
         pc_ID    <= pc_IF;
         valid_ID <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stop_IF && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed vector bench for if_id_stage with a 4-bit stall counter so that
// saturation and reset-during-hold can be reached in a short run.
module tb_if_id_stage;
   import if_id_stage_pkg::*;

   localparam int CNT_W = 4;

   logic                  clk;
   logic                  rst_n;
   logic [WIDTH_INST-1:0] inst_IF;
   logic [WIDTH_PC-1:0]   pc_IF;
   logic                  flush;
   logic                  mem_busy;
   logic                  ex_memRead;
   logic [4:0]            ex_rd;
   logic [WIDTH_INST-1:0] inst_ID;
   logic [WIDTH_PC-1:0]   pc_ID;
   logic                  valid_ID;
   logic                  stop_IF;
   logic                  bubble_EX;
   logic [CNT_W-1:0]      stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   if_id_stage #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inst_IF    (inst_IF),
      .pc_IF      (pc_IF),
      .flush      (flush),
      .mem_busy   (mem_busy),
      .ex_memRead (ex_memRead),
      .ex_rd      (ex_rd),
      .inst_ID    (inst_ID),
      .pc_ID      (pc_ID),
      .valid_ID   (valid_ID),
      .stop_IF    (stop_IF),
      .bubble_EX  (bubble_EX),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst_if;
      logic [31:0] pc_if;
      logic        flush;
      logic        mem_busy;
      logic        ex_mem_read;
      logic [4:0]  ex_rd;
      logic        exp_stop;
      logic        exp_bubble;
      logic [31:0] exp_inst;
      logic [31:0] exp_pc;
      logic        exp_valid;
      logic [3:0]  exp_cnt;
      state_t      exp_state;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      inst_IF    = v.inst_if;
      pc_IF      = v.pc_if;
      flush      = v.flush;
      mem_busy   = v.mem_busy;
      ex_memRead = v.ex_mem_read;
      ex_rd      = v.ex_rd;
      #1;
      chk($sformatf("v%0d_stop_IF", idx), {31'd0, stop_IF}, {31'd0, v.exp_stop});
      chk($sformatf("v%0d_bubble_EX", idx), {31'd0, bubble_EX}, {31'd0, v.exp_bubble});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_inst_ID", idx), inst_ID, v.exp_inst);
      chk($sformatf("v%0d_pc_ID", idx), pc_ID, v.exp_pc);
      chk($sformatf("v%0d_valid_ID", idx), {31'd0, valid_ID}, {31'd0, v.exp_valid});
      chk($sformatf("v%0d_stall_cnt", idx), {28'd0, stall_cnt}, {28'd0, v.exp_cnt});
      chk($sformatf("v%0d_state", idx), {30'd0, dut.state}, {30'd0, v.exp_state});
   endtask

   initial begin
      logic [3:0] exp_cnt;

      //          inst_if        pc_if    fl mb mr rd   stp bub exp_inst       exp_pc   v  cnt  state
      vecs[0]  = '{32'h00500093, 32'h00, 0, 0, 0, 5'd0, 0, 0, 32'h00500093, 32'h00, 1, 4'd0, ST_RUN};
      vecs[1]  = '{32'h002081B3, 32'h04, 0, 0, 0, 5'd0, 0, 0, 32'h002081B3, 32'h04, 1, 4'd0, ST_RUN};
      // add x3,x1,x2 in ID vs load to x1
      vecs[2]  = '{32'h00400113, 32'h08, 0, 0, 1, 5'd1, 1, 1, 32'h002081B3, 32'h04, 1, 4'd1, ST_LU_STALL};
      vecs[3]  = '{32'h00400113, 32'h08, 0, 0, 0, 5'd1, 0, 0, 32'h00400113, 32'h08, 1, 4'd1, ST_RUN};
      vecs[4]  = '{32'h123450B7, 32'h0C, 0, 0, 1, 5'd0, 0, 0, 32'h123450B7, 32'h0C, 1, 4'd1, ST_RUN};
      // lui's rs1 field is x8: must not match a load to x8
      vecs[5]  = '{32'h00108313, 32'h10, 0, 0, 1, 5'd8, 0, 0, 32'h00108313, 32'h10, 1, 4'd1, ST_RUN};
      vecs[6]  = '{32'h00512023, 32'h14, 0, 0, 1, 5'd5, 0, 0, 32'h00512023, 32'h14, 1, 4'd1, ST_RUN};
      // sw x5,0(x2) in ID vs load to x5 (rs2 hazard)
      vecs[7]  = '{32'h00000013, 32'h18, 0, 0, 1, 5'd5, 1, 1, 32'h00512023, 32'h14, 1, 4'd2, ST_LU_STALL};
      vecs[8]  = '{32'h00000013, 32'h18, 0, 0, 0, 5'd5, 0, 0, 32'h00000013, 32'h18, 1, 4'd2, ST_RUN};
      vecs[9]  = '{32'h00100093, 32'h1C, 0, 1, 0, 5'd0, 1, 0, 32'h00000013, 32'h18, 1, 4'd3, ST_MEM_HOLD};
      vecs[10] = '{32'h00100093, 32'h1C, 0, 1, 0, 5'd0, 1, 0, 32'h00000013, 32'h18, 1, 4'd4, ST_MEM_HOLD};
      vecs[11] = '{32'h00100093, 32'h1C, 0, 1, 0, 5'd0, 1, 0, 32'h00000013, 32'h18, 1, 4'd5, ST_MEM_HOLD};
      vecs[12] = '{32'h00100093, 32'h1C, 0, 0, 0, 5'd0, 0, 0, 32'h00100093, 32'h1C, 1, 4'd5, ST_RUN};
      vecs[13] = '{32'h002081B3, 32'h20, 0, 0, 0, 5'd0, 0, 0, 32'h002081B3, 32'h20, 1, 4'd5, ST_RUN};
      // flush during a live load-use on rs2=x2
      vecs[14] = '{32'h00000093, 32'h40, 1, 0, 1, 5'd2, 0, 0, 32'h00000013, 32'h40, 0, 4'd5, ST_RUN};
      vecs[15] = '{32'h00500093, 32'h44, 1, 1, 0, 5'd0, 0, 0, 32'h00000013, 32'h44, 0, 4'd5, ST_RUN};
      vecs[16] = '{32'h00500093, 32'h48, 0, 0, 0, 5'd0, 0, 0, 32'h00500093, 32'h48, 1, 4'd5, ST_RUN};

      rst_n      = 1'b0;
      inst_IF    = 32'h00500093;
      pc_IF      = 32'h0;
      flush      = 1'b0;
      mem_busy   = 1'b1;
      ex_memRead = 1'b0;
      ex_rd      = 5'd0;
      #12;
      chk("rst_inst_ID", inst_ID, NOP_INST);
      chk("rst_pc_ID", pc_ID, 32'h0);
      chk("rst_valid_ID", {31'd0, valid_ID}, 32'd0);
      chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
      chk("rst_stop_IF", {31'd0, stop_IF}, 32'd0);
      chk("rst_bubble_EX", {31'd0, bubble_EX}, 32'd0);
      mem_busy = 1'b0;
      rst_n    = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         run_vec(vecs[i], i);
      end

      // Long memory stall: counter climbs from 5 and saturates at 15.
      exp_cnt = 4'd5;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         inst_IF    = 32'h00700393;
         pc_IF      = 32'h4C;
         flush      = 1'b0;
         mem_busy   = 1'b1;
         ex_memRead = 1'b0;
         ex_rd      = 5'd0;
         #1;
         chk($sformatf("sat%0d_stop_IF", i), {31'd0, stop_IF}, 32'd1);
         chk($sformatf("sat%0d_bubble_EX", i), {31'd0, bubble_EX}, 32'd0);
         @(posedge clk);
         #1;
         if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
         chk($sformatf("sat%0d_stall_cnt", i), {28'd0, stall_cnt}, {28'd0, exp_cnt});
         chk($sformatf("sat%0d_inst_ID", i), inst_ID, 32'h00500093);
         chk($sformatf("sat%0d_pc_ID", i), pc_ID, 32'h48);
      end

      // Asynchronous reset in the middle of MEM_HOLD, mem_busy still high.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_inst_ID", inst_ID, NOP_INST);
      chk("arst_pc_ID", pc_ID, 32'h0);
      chk("arst_valid_ID", {31'd0, valid_ID}, 32'd0);
      chk("arst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
      chk("arst_stop_IF", {31'd0, stop_IF}, 32'd0);
      chk("arst_bubble_EX", {31'd0, bubble_EX}, 32'd0);
      chk("arst_state", {30'd0, dut.state}, {30'd0, ST_RUN});

      #10;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline register and hazard controller between the instruction-fetch stage and the decode stage of the 5-stage RV32I core.
- Captures the fetched instruction and PC each cycle and presents them to ID as inst_ID/pc_ID.
- Detects load-use hazards and external memory stalls, drives stop_IF back to fetch, and drives bubble_EX to the ID/EX register.
- Squashes the held instruction on flush and keeps a saturating stall-cycle counter for performance debug.

Parameters:
NOP_INST, 32'h0000_0013, instruction injected on reset/flush (addi x0,x0,0)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  core clock, posedge
rst_n  in  1  asynchronous active-low reset
inst_IF  in  `WIDTH_INST  instruction from fetch
pc_IF  in  `WIDTH_PC  PC of inst_IF
flush  in  1  squash the instruction in ID (redirect resolved later than ID)
mem_busy  in  1  data memory not ready; freeze IF and ID
ex_memRead  in  1  instruction in EX is a load
ex_rd  in  5  destination register of instruction in EX
inst_ID  out  `WIDTH_INST  registered instruction to ID
pc_ID  out  `WIDTH_PC  registered PC to ID
valid_ID  out  1  inst_ID is a real instruction (not injected NOP)
stop_IF  out  1  hold the fetch PC this cycle (combinational)
bubble_EX  out  1  ID/EX captures NOP this cycle (combinational)
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (async, rst_n=0): inst_ID=NOP_INST, pc_ID=0, valid_ID=0, stall_cnt=0, state=RUN. stop_IF and bubble_EX are 0 while in reset.
- Source-register use, decoded from inst_ID[6:0]:
  - rs1 = inst_ID[19:15] is used for every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 = inst_ID[24:20] is used only for BRANCH (1100011), STORE (0100011) and OP (0110011).
- load_use = valid_ID & ex_memRead & (ex_rd != 0) & ((rs1 used & rs1 == ex_rd) | (rs2 used & rs2 == ex_rd)).
- FSM states:
  - RUN: normal flow.
  - LU_STALL: exactly one cycle of load-use stall.
  - MEM_HOLD: freeze for as long as mem_busy is high.
- State transitions, by priority:
  - flush=1 → RUN, regardless of state.
  - Otherwise mem_busy=1 → MEM_HOLD.
  - Otherwise load_use in RUN → LU_STALL.
  - LU_STALL → RUN after one cycle.
  - MEM_HOLD → RUN when mem_busy=0.
- Combinational outputs:
  - stop_IF = ~flush & (mem_busy | (state==RUN & load_use)).
  - bubble_EX = ~flush & ~mem_busy & state==RUN & load_use. There is no bubble during MEM_HOLD; the whole pipe freezes instead.
- Register update at posedge:
  - flush: inst_ID←NOP_INST, valid_ID←0; pc_ID←pc_IF.
  - else stop_IF: hold inst_ID, pc_ID, valid_ID.
  - else: inst_ID←inst_IF, pc_ID←pc_IF, valid_ID←1.
- LU_STALL releases on the following cycle because the load has moved on from EX. Its state is informational; the hold decision uses only the combinational load_use/mem_busy terms.
- flush and mem_busy in the same cycle: flush wins for the ID register. stop_IF=0 on that cycle; fetch is assumed to be redirecting.
- stall_cnt increments on every cycle with stop_IF=1 and saturates at all-ones. It clears only on reset.
- Reset asserted mid-stall: outputs return to reset values immediately and the FSM goes to RUN.
- Latency: inst_IF appears on inst_ID one cycle later when not stalled.

Decomposition:
- Shared param.v gets:
  - opcode constants: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_BRANCH, OPC_STORE, OPC_OP;
  - `NOP_INST;
  - FSM state encodings: ST_RUN, ST_LU_STALL, ST_MEM_HOLD (2 bits).
- One natural sub-module, hazard_detect: purely combinational rs1/rs2 use decode plus the load_use compare. The FSM and registers stay in if_id_stage.

Test Plan:
1. Reset release with mem_busy=0, inst_IF=0x00500093, pc_IF=0x0 → next edge: inst_ID=0x00500093, pc_ID=0, valid_ID=1, stop_IF=0.
2. Load-use hazard:
   - Stimulus: inst_ID=add x3,x1,x2 (0x002081B3), ex_memRead=1, ex_rd=1.
   - Same cycle: stop_IF=1, bubble_EX=1.
   - Next edge: inst_ID unchanged, state=LU_STALL. With ex_memRead=0 it proceeds on the following edge.
   - stall_cnt=1.
3. No false hazard:
   - Stimulus: inst_ID=lui x1,0x12345 (0x123450B7), ex_memRead=1, ex_rd=0 (x0).
   - Same cycle: stop_IF=0, bubble_EX=0.
   - Also: ex_rd=5 with inst_ID=addi x6,x1,1 → no stall.
4. mem_busy held high for 3 cycles → stop_IF=1 for 3 cycles, bubble_EX=0, inst_ID/pc_ID frozen, stall_cnt +3. The next edge after release captures inst_IF.
5. flush asserted during a load_use cycle with pc_IF=0x40 → stop_IF=0, bubble_EX=0; next edge: inst_ID=0x00000013, valid_ID=0, pc_ID=0x40, state=RUN.
6. Force stall_cnt to all-ones (CNT_W=4: 15 stall cycles) then stall once more → stall_cnt stays 15. Assert rst_n=0 mid-MEM_HOLD → all outputs at reset values without waiting for a clock edge.
